alu_result_capture: RTL and testbench
=====================================

// Module: alu_result_capture
// PURPOSE
//  Consumer end of the 32-bit ALU output interface: registers Y_hi/Y_lo and C/V/N/Z into
//  ALU_OUT, HI, LO and a flag register when control strobes LD. Mult/div results commit to
//  HI/LO only after MD_LAT cycles. Serves registered read-backs (mfhi/mflo/ALU_OUT/flags)
//  to the datapath and raises STALL on reads of pending HI/LO.
// PARAMETERS
//  MD_LAT  4  cycles from mult/div LD to HI/LO commit; legal range 1..16
// PORTS
//  clk     in   1   sole clock, rising edge
//  reset   in   1   asynchronous, active-low; clears all state
//  LD      in   1   capture strobe for the current ALU result
//  FS      in   5   function select accompanying LD (5'h1E mult, 5'h1F div)
//  Y_hi    in   32  ALU upper result
//  Y_lo    in   32  ALU lower result
//  C,V,N,Z in   1   ALU flags
//  RD_REQ  in   1   read request
//  SEL     in   2   read source: 00 ALU_OUT, 01 LO, 10 HI, 11 {28'b0,C,V,N,Z}
//  D_OUT   out  32  read data, registered
//  D_VLD   out  1   D_OUT valid, one-cycle pulse
//  STALL   out  1   combinational; read refused this cycle
//  BUSY    out  1   mult/div commit pending (state == MD_WAIT)
// BEHAVIOUR
//  Reset: ALU_OUT, HI, LO, flags, D_OUT, counter = 0; D_VLD = 0; state IDLE.
//   Reset mid-MD_WAIT discards the shadow; no commit occurs.
//  Non-md LD (FS != 1E/1F): ALU_OUT <= Y_lo; {C,V,N,Z} <= inputs, at the same edge.
//  Md LD: shadow <= {Y_hi,Y_lo}; cnt <= MD_LAT-1; state -> MD_WAIT; N,Z updated at the
//   same edge; C,V retained (the ALU drives C as X for md ops).
//  FSM IDLE -> MD_WAIT on md LD. In MD_WAIT: cnt decrements each edge. At the edge where
//   cnt == 0: {HI,LO} <= shadow; state -> IDLE.
//  Md LD while in MD_WAIT: shadow overwritten, cnt reloaded, prior result never commits.
//   This takes priority over a commit due at the same edge.
//  Non-md LD while in MD_WAIT: updates ALU_OUT and flags normally; the wait continues.
//  STALL = RD_REQ && SEL in {01,10} && state == MD_WAIT.
//  Accepted read (RD_REQ && !STALL): D_OUT <= selected source; D_VLD = 1 next cycle.
//   Otherwise D_VLD = 0 and D_OUT holds its value.
//  Read and LD at the same edge: the read returns the pre-edge value (read-before-write).
//  Read of HI/LO in the cycle after commit returns the committed value. STALL is never
//   asserted in IDLE.
//  Widths: all datapath registers are 32 bits; cnt is 4 bits; no arithmetic beyond the
//   decrement.
// STRUCTURE
//  Shared package: FS_MULT=5'h1E, FS_DIV=5'h1F, SEL_* encodings, state enum {IDLE,MD_WAIT}.
//  Single module with no sub-modules. The FSM and counter are one always block; the
//   capture registers and read port are separate always blocks.
// TESTING
//  1 Reset: hold reset=0 mid-activity -> all outputs 0, BUSY=0; release -> reads of every
//    SEL return 0.
//  2 Add: LD, FS=02, Y_lo=32'h0000_0007, Z=0 -> next cycle RD_REQ SEL=00 -> D_OUT=7,
//    D_VLD pulse.
//  3 Mult, MD_LAT=4: LD, FS=1E, Y_hi=1, Y_lo=32'hFFFF_FFFE. Read HI each cycle ->
//    STALL=1 for 4 cycles, then D_OUT=1. LO reads FFFF_FFFE. C,V unchanged.
//  4 Back-to-back md: second div LD 2 cycles after mult -> BUSY stays high MD_LAT more
//    cycles; HI/LO = div values only; mult values are never visible.
//  5 Simultaneous: LD of 32'h55 with read SEL=00 when ALU_OUT=32'hAA -> D_OUT=AA; next
//    read gives 55.
//  6 Reset mid-MD_WAIT, cnt=2 -> HI=LO=0 after release; BUSY=0; no late commit.

Source files
------------

// File: rtl/alu_result_capture_pkg.sv
// Shared encodings for the ALU result capture block: function selects,
// read-source selects, FSM state type and the packed flag register layout.
package alu_result_capture_pkg;

  localparam logic [4:0] FS_MULT = 5'h1E;
  localparam logic [4:0] FS_DIV  = 5'h1F;

  localparam logic [1:0] SEL_ALU_OUT = 2'b00;
  localparam logic [1:0] SEL_LO      = 2'b01;
  localparam logic [1:0] SEL_HI      = 2'b10;
  localparam logic [1:0] SEL_FLAGS   = 2'b11;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

  function automatic logic is_md_fs(input logic [4:0] fs);
    return (fs == FS_MULT) || (fs == FS_DIV);
  endfunction

endpackage

// File: rtl/alu_result_capture.sv
// Consumer end of the ALU output interface: captures results and flags,
// delays mult/div commits into HI/LO, and serves registered read-backs.
module alu_result_capture
  import alu_result_capture_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        LD,
  input  logic [4:0]  FS,
  input  logic [31:0] Y_hi,
  input  logic [31:0] Y_lo,
  input  logic        C,
  input  logic        V,
  input  logic        N,
  input  logic        Z,
  input  logic        RD_REQ,
  input  logic [1:0]  SEL,
  output logic [31:0] D_OUT,
  output logic        D_VLD,
  output logic        STALL,
  output logic        BUSY
);

  localparam logic [3:0] CNT_LOAD = 4'(MD_LAT - 1);

  logic md_ld;
  logic alu_ld;

  assign md_ld  = LD && is_md_fs(FS);
  assign alu_ld = LD && !md_ld;

  // ---------------------------------------------------------------------------
  // Mult/div commit FSM and latency counter
  // ---------------------------------------------------------------------------
  state_e      state_d, state_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [63:0] shadow_d, shadow_q;
  logic        commit;

  // A new md load always restarts the wait, even if a commit was due now.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    if (md_ld) begin
      state_d  = MD_WAIT;
      cnt_d    = CNT_LOAD;
      shadow_d = {Y_hi, Y_lo};
    end else if (state_q == MD_WAIT) begin
      if (cnt_q == 4'd0) begin
        commit  = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      shadow_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural capture registers
  // ---------------------------------------------------------------------------
  logic [31:0] alu_out_d, alu_out_q;
  logic [31:0] hi_d, hi_q;
  logic [31:0] lo_d, lo_q;
  flags_t      flags_d, flags_q;

  // C is undefined from the ALU on md ops, so only N/Z follow an md load.
  always_comb begin
    alu_out_d = alu_out_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    flags_d   = flags_q;
    if (alu_ld) begin
      alu_out_d = Y_lo;
      flags_d   = '{c: C, v: V, n: N, z: Z};
    end
    if (md_ld) begin
      flags_d.n = N;
      flags_d.z = Z;
    end
    if (commit) begin
      hi_d = shadow_q[63:32];
      lo_d = shadow_q[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      flags_q   <= '0;
    end else begin
      alu_out_q <= alu_out_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      flags_q   <= flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // Handshake: RD_REQ is the request and !STALL is the grant. A read is taken
  // at a rising edge where RD_REQ=1 and STALL=0; D_OUT carries the pre-edge
  // value of the source and D_VLD pulses for exactly the following cycle.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_src;
  logic        rd_accept;
  logic [31:0] d_out_d, d_out_q;
  logic        d_vld_d, d_vld_q;

  assign STALL     = RD_REQ && ((SEL == SEL_LO) || (SEL == SEL_HI)) && (state_q == MD_WAIT);
  assign rd_accept = RD_REQ && !STALL;

  always_comb begin
    case (SEL)
      SEL_ALU_OUT: rd_src = alu_out_q;
      SEL_LO:      rd_src = lo_q;
      SEL_HI:      rd_src = hi_q;
      SEL_FLAGS:   rd_src = {28'd0, flags_q};
      default:     rd_src = 32'd0;
    endcase
  end

  always_comb begin
    d_out_d = d_out_q;
    d_vld_d = rd_accept;
    if (rd_accept) begin
      d_out_d = rd_src;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out_q <= 32'd0;
      d_vld_q <= 1'b0;
    end else begin
      d_out_q <= d_out_d;
      d_vld_q <= d_vld_d;
    end
  end

  assign D_OUT = d_out_q;
  assign D_VLD = d_vld_q;
  assign BUSY  = (state_q == MD_WAIT);

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed bench for alu_result_capture: a time-stamped reference model of the
// register file plus hand-computed literal checks on each scenario.
module tb_alu_result_capture;

  localparam int unsigned MD_LAT = 4;

  logic        clk;
  logic        reset;
  logic        LD;
  logic [4:0]  FS;
  logic [31:0] Y_hi;
  logic [31:0] Y_lo;
  logic        C, V, N, Z;
  logic        RD_REQ;
  logic [1:0]  SEL;
  logic [31:0] D_OUT;
  logic        D_VLD;
  logic        STALL;
  logic        BUSY;

  int n_checks = 0;
  int n_fail   = 0;
  logic stall_s;
  logic busy_s;

  alu_result_capture #(.MD_LAT(MD_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .LD     (LD),
    .FS     (FS),
    .Y_hi   (Y_hi),
    .Y_lo   (Y_lo),
    .C      (C),
    .V      (V),
    .N      (N),
    .Z      (Z),
    .RD_REQ (RD_REQ),
    .SEL    (SEL),
    .D_OUT  (D_OUT),
    .D_VLD  (D_VLD),
    .STALL  (STALL),
    .BUSY   (BUSY)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // A pending md result commits MD_LAT edges after its load edge unless a
  // newer md load arrives first.
  logic [31:0] m_alu, m_hi, m_lo, m_dout;
  logic [3:0]  m_flags;
  logic        m_vld, m_pend;
  logic [63:0] m_shadow;
  int          m_edge, m_due;

  function automatic logic [31:0] m_src(input logic [1:0] s);
    case (s)
      2'b00:   return m_alu;
      2'b01:   return m_lo;
      2'b10:   return m_hi;
      default: return {28'd0, m_flags};
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_alu <= 0; m_hi <= 0; m_lo <= 0; m_dout <= 0; m_flags <= 0;
      m_vld <= 0; m_pend <= 0; m_shadow <= 0; m_edge <= 0; m_due <= 0;
    end else begin
      m_edge <= m_edge + 1;
      if (RD_REQ && !(m_pend && (SEL == 2'b01 || SEL == 2'b10))) begin
        m_dout <= m_src(SEL);
        m_vld  <= 1'b1;
      end else begin
        m_vld <= 1'b0;
      end
      if (LD && (FS == 5'h1E || FS == 5'h1F)) begin
        m_pend      <= 1'b1;
        m_due       <= m_edge + int'(MD_LAT);
        m_shadow    <= {Y_hi, Y_lo};
        m_flags[1:0] <= {N, Z};
      end else begin
        if (m_pend && m_edge == m_due) begin
          m_pend <= 1'b0;
          m_hi   <= m_shadow[63:32];
          m_lo   <= m_shadow[31:0];
        end
        if (LD) begin
          m_alu   <= Y_lo;
          m_flags <= {C, V, N, Z};
        end
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at %0t: got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // One cycle: apply inputs, check STALL before the edge, check registered
  // outputs just after it.
  task automatic drive(input logic ld, input logic [4:0] fs, input logic [31:0] yh,
                       input logic [31:0] yl, input logic [3:0] f,
                       input logic rd, input logic [1:0] sel);
    LD = ld; FS = fs; Y_hi = yh; Y_lo = yl; {C, V, N, Z} = f; RD_REQ = rd; SEL = sel;
    #1;
    stall_s = STALL;
    busy_s  = BUSY;
    chk("cmp_stall", {31'd0, STALL}, {31'd0, RD_REQ && (SEL == 2'b01 || SEL == 2'b10) && m_pend});
    @(posedge clk);
    #1;
    chk("cmp_d_out", D_OUT, m_dout);
    chk("cmp_d_vld", {31'd0, D_VLD}, {31'd0, m_vld});
    chk("cmp_busy",  {31'd0, BUSY},  {31'd0, m_pend});
    LD = 1'b0;
    RD_REQ = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 5'h00, 32'd0, 32'd0, 4'h0, 1'b0, 2'b00);
  endtask

  task automatic rd(input logic [1:0] sel);
    drive(1'b0, 5'h00, 32'd0, 32'd0, 4'h0, 1'b1, sel);
  endtask

  task automatic alu(input logic [31:0] yl, input logic [3:0] f);
    drive(1'b1, 5'h02, 32'd0, yl, f, 1'b0, 2'b00);
  endtask

  task automatic md(input logic [4:0] fs, input logic [31:0] yh, input logic [31:0] yl,
                    input logic [3:0] f);
    drive(1'b1, fs, yh, yl, f, 1'b0, 2'b00);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1;
    LD = 0; FS = 0; Y_hi = 0; Y_lo = 0; {C, V, N, Z} = 4'h0; RD_REQ = 0; SEL = 0;
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 1: reset mid-activity, then every source reads back zero
    idle();
    rd(2'b10);
    chk("t1_stall_in_reset", {31'd0, stall_s}, 32'd0);
    reset = 1'b1;
    alu(32'h0000_1234, 4'hF);
    rd(2'b00);
    chk("t1_pre_reset_read", D_OUT, 32'h0000_1234);
    md(5'h1E, 32'd5, 32'd6, 4'h0);
    idle();
    reset = 1'b0;
    #1;
    chk("t1_rst_d_out", D_OUT, 32'd0);
    chk("t1_rst_d_vld", {31'd0, D_VLD}, 32'd0);
    chk("t1_rst_busy",  {31'd0, BUSY}, 32'd0);
    idle();
    reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rd(2'(s));
      chk("t1_read_zero", D_OUT, 32'd0);
      chk("t1_read_vld",  {31'd0, D_VLD}, 32'd1);
    end
    repeat (6) idle();
    rd(2'b10);
    chk("t1_no_late_commit", D_OUT, 32'd0);

    // 2: add result read back next cycle, D_VLD is a single pulse
    alu(32'h0000_0007, 4'b1100);
    rd(2'b00);
    chk("t2_d_out", D_OUT, 32'd7);
    chk("t2_d_vld", {31'd0, D_VLD}, 32'd1);
    idle();
    chk("t2_vld_drop", {31'd0, D_VLD}, 32'd0);
    chk("t2_hold", D_OUT, 32'd7);

    // 3: mult commit after MD_LAT, C/V retained
    md(5'h1E, 32'd1, 32'hFFFF_FFFE, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      rd(2'b10);
      chk("t3_stall", {31'd0, stall_s}, 32'd1);
    end
    chk("t3_busy_clear", {31'd0, BUSY}, 32'd0);
    rd(2'b10);
    chk("t3_no_stall", {31'd0, stall_s}, 32'd0);
    chk("t3_hi", D_OUT, 32'd1);
    rd(2'b01);
    chk("t3_lo", D_OUT, 32'hFFFF_FFFE);
    rd(2'b11);
    chk("t3_flags", D_OUT, 32'h0000_000D);

    // 4a: div two cycles after mult, only div values land
    md(5'h1E, 32'hAAAA_0001, 32'hBBBB_0002, 4'h0);
    idle();
    md(5'h1F, 32'h0000_0011, 32'h0000_0022, 4'h0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t4_busy_held", {31'd0, busy_s}, 32'd1);
    end
    chk("t4_busy_done", {31'd0, BUSY}, 32'd0);
    rd(2'b10);
    chk("t4_hi", D_OUT, 32'h0000_0011);
    rd(2'b01);
    chk("t4_lo", D_OUT, 32'h0000_0022);

    // 4b: md load on the very edge a commit was due wins
    md(5'h1E, 32'd5, 32'd6, 4'h0);
    repeat (3) idle();
    md(5'h1F, 32'd9, 32'hA, 4'h0);
    chk("t4b_still_busy", {31'd0, BUSY}, 32'd1);
    repeat (4) idle();
    chk("t4b_busy_done", {31'd0, BUSY}, 32'd0);
    rd(2'b10);
    chk("t4b_hi", D_OUT, 32'd9);
    rd(2'b01);
    chk("t4b_lo", D_OUT, 32'hA);

    // 5: read-before-write on ALU_OUT
    alu(32'h0000_00AA, 4'h0);
    drive(1'b1, 5'h02, 32'd0, 32'h0000_0055, 4'h0, 1'b1, 2'b00);
    chk("t5_old", D_OUT, 32'h0000_00AA);
    rd(2'b00);
    chk("t5_new", D_OUT, 32'h0000_0055);

    // 7: non-md load during the wait updates ALU_OUT, wait continues
    md(5'h1E, 32'd3, 32'd4, 4'h0);
    alu(32'h0000_0099, 4'h0);
    rd(2'b00);
    chk("t7_alu", D_OUT, 32'h0000_0099);
    chk("t7_busy", {31'd0, BUSY}, 32'd1);
    repeat (2) idle();
    rd(2'b10);
    chk("t7_hi", D_OUT, 32'd3);

    // 6: reset with cnt=2 discards the shadow
    md(5'h1F, 32'h7777_7777, 32'h8888_8888, 4'h0);
    idle();
    reset = 1'b0;
    #1;
    chk("t6_busy_rst", {31'd0, BUSY}, 32'd0);
    idle();
    reset = 1'b1;
    repeat (6) idle();
    chk("t6_busy", {31'd0, BUSY}, 32'd0);
    rd(2'b10);
    chk("t6_hi", D_OUT, 32'd0);
    rd(2'b01);
    chk("t6_lo", D_OUT, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
